// File: rtl/data_demux_router.sv
// 1-to-4 buffered demultiplexer: routes one word per valid/ready handshake into a 2-deep FIFO per channel.
// Optional per-channel pop counters are compiled in when DEMUX_XFER_CNT_EN is defined.
`ifndef DATA_BUS_LEN
`define DATA_BUS_LEN 32
`endif

module data_demux_router #(
    parameter int DATA_W = `DATA_BUS_LEN,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [4*DATA_W-1:0] out_data,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready
`ifdef DEMUX_XFER_CNT_EN
    ,
    input  logic                cnt_clr,
    output logic [4*CNT_W-1:0]  xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } ch_state_e;

    if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
        $error("data_demux_router: DATA_W and CNT_W must be positive");
    end

    ch_state_e         state_q [4];
    ch_state_e         state_d [4];
    logic [DATA_W-1:0] head_q  [4];
    logic [DATA_W-1:0] head_d  [4];
    logic [DATA_W-1:0] tail_q  [4];
    logic [DATA_W-1:0] tail_d  [4];
    logic [3:0]        push_ch;
    logic [3:0]        pop_ch;

    // Ready depends only on the selected channel's registered state, never on out_ready.
    assign in_ready = (state_q[in_sel] != ST_FULL);

    always_comb begin
        out_valid = 4'b0000;
        out_data  = '0;
        for (int i = 0; i < 4; i++) begin
            out_valid[i]                = (state_q[i] != ST_EMPTY);
            out_data[i*DATA_W +: DATA_W] = head_q[i];
        end
    end

    always_comb begin
        push_ch = 4'b0000;
        pop_ch  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            push_ch[i] = in_valid && in_ready && (in_sel == 2'(i));
            pop_ch[i]  = out_valid[i] && out_ready[i];
        end
    end

    // Head register is zeroed whenever a channel drains so out_data reads 0 while invalid.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        for (int i = 0; i < 4; i++) begin
            case (state_q[i])
                ST_EMPTY: begin
                    if (push_ch[i]) begin
                        state_d[i] = ST_ONE;
                        head_d[i]  = in_data;
                    end
                end
                ST_ONE: begin
                    if (push_ch[i] && pop_ch[i]) begin
                        head_d[i] = in_data;
                    end else if (push_ch[i]) begin
                        state_d[i] = ST_FULL;
                        tail_d[i]  = in_data;
                    end else if (pop_ch[i]) begin
                        state_d[i] = ST_EMPTY;
                        head_d[i]  = '0;
                    end
                end
                ST_FULL: begin
                    if (pop_ch[i]) begin
                        state_d[i] = ST_ONE;
                        head_d[i]  = tail_q[i];
                        tail_d[i]  = '0;
                    end
                end
                default: begin
                    state_d[i] = ST_EMPTY;
                    head_d[i]  = '0;
                    tail_d[i]  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_EMPTY;
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                head_q[i]  <= head_d[i];
                tail_q[i]  <= tail_d[i];
            end
        end
    end

`ifdef DEMUX_XFER_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Clear wins over a same-cycle pop; counters stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (pop_ch[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        xfer_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            xfer_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule
